// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port memory with fixed read latency.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise the data port wins ties.
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    grant,
    output logic [1:0]    state_dbg
);

    // Handshake: a port holds req (and its addr/we/wdata) until it sees a one-cycle ack.
    // The request is sampled only in IDLE; everything after that runs from latched copies.

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [1:0]  grant_r;
    logic        we_r;
    logic        pick_dm;
    logic        any_req;

    assign any_req = if_req || dm_req;

`ifdef ARB_RR_EN
    logic last_dm;

    // On a tie the port that was not granted last wins; a lone requester always wins.
    assign pick_dm = dm_req && (!if_req || !last_dm);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            last_dm <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_dm <= pick_dm;
        end
    end
`else
    assign pick_dm = dm_req;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= IDLE;
            grant_r   <= 2'b00;
            we_r      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt       <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_r  <= pick_dm ? 2'b10 : 2'b01;
                        we_r     <= pick_dm && dm_we;
                        mem_addr <= pick_dm ? dm_addr : if_addr;
                        if (pick_dm) begin
                            mem_wdata <= dm_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (!we_r) begin
                        cnt <= LAT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    // Counter at 1 marks the cycle the memory presents read data.
                    if (cnt == 3'd1) begin
                        if (grant_r[1]) begin
                            dm_rdata <= mem_rdata;
                        end else begin
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    grant_r <= 2'b00;
                end
                default: begin
                    grant_r <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = we_r ? DONE : WAIT;
            WAIT:    if (cnt == 3'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en = 1'b0;
        mem_we = 1'b0;
        if_ack = 1'b0;
        dm_ack = 1'b0;
        busy   = (state != IDLE);
        if (state == ISSUE) begin
            mem_en = 1'b1;
            mem_we = we_r;
        end
        if (state == DONE) begin
            if_ack = grant_r[0];
            dm_ack = grant_r[1];
        end
    end

    assign grant     = grant_r;
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (MEM_LAT 1, 2, 7) share the request inputs,
// each with its own fixed-latency memory model. Build with ARB_RR_EN to run the round-robin scenario.
module tb_mem_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          load_en = 1'b0;
    logic [9:0]    load_addr = '0;
    logic [DW-1:0] load_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 7);
        logic          if_ack, dm_ack, mem_en, mem_we, busy;
        logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
        logic [AW-1:0] mem_addr;
        logic [1:0]    grant, state_dbg;
        logic [DW-1:0] mem [1024];
        logic [AW-1:0] rd_addr [8];
        logic          rd_vld [8];

        always @(posedge Clk) begin
            if (load_en) mem[load_addr] <= load_data;
            else if (mem_en && mem_we) mem[mem_addr[9:0]] <= mem_wdata;
            rd_addr[0] <= mem_addr;
            rd_vld[0]  <= mem_en && !mem_we;
            for (int i = 1; i < 8; i++) begin
                rd_addr[i] <= rd_addr[i-1];
                rd_vld[i]  <= rd_vld[i-1];
            end
        end

        assign mem_rdata = rd_vld[LAT-1] ? mem[rd_addr[LAT-1][9:0]] : 16'hDEAD;

        mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) u_dut (
            .Clk(Clk), .Reset(Reset),
            .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
            .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
            .dm_ack(dm_ack), .dm_rdata(dm_rdata),
            .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
            .mem_rdata(mem_rdata), .busy(busy), .grant(grant), .state_dbg(state_dbg)
        );
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        repeat (12) tick();
    endtask

    task automatic preload(input logic [9:0] a, input logic [DW-1:0] d);
        load_en = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({g_dut[1].if_ack, g_dut[1].dm_ack, g_dut[1].mem_en, g_dut[1].mem_we, g_dut[1].busy, g_dut[1].grant} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {g_dut[1].if_ack, g_dut[1].dm_ack, g_dut[1].mem_en, g_dut[1].mem_we, g_dut[1].busy, g_dut[1].grant});
        end
        n_cmp++;
        if ({g_dut[1].if_rdata, g_dut[1].dm_rdata} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h expected 00000000", {g_dut[1].if_rdata, g_dut[1].dm_rdata});
        end
        n_cmp++;
        if ({g_dut[1].mem_addr, g_dut[1].mem_wdata} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mem_bus: got %h expected 00000000", {g_dut[1].mem_addr, g_dut[1].mem_wdata});
        end
        n_cmp++;
        if (g_dut[1].state_dbg !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_state: got %b expected 00", g_dut[1].state_dbg);
        end
        Reset = 1'b1;
        preload(10'h010, 16'hBEEF);
        settle();
    endtask

    task automatic test_if_read();
        if_req = 1'b1;
        if_addr = 16'h0010;
        tick();
        n_cmp++;
        if ({g_dut[1].mem_en, g_dut[1].mem_we, g_dut[1].grant, g_dut[1].mem_addr} !== {1'b1, 1'b0, 2'b01, 16'h0010}) begin
            n_bad++;
            $display("FAIL if_issue: got en=%b we=%b grant=%b addr=%h expected en=1 we=0 grant=01 addr=0010",
                     g_dut[1].mem_en, g_dut[1].mem_we, g_dut[1].grant, g_dut[1].mem_addr);
        end
        tick();
        tick();
        n_cmp++;
        if (g_dut[1].if_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL if_early_ack: got %b expected 0", g_dut[1].if_ack);
        end
        tick();
        n_cmp++;
        if ({g_dut[1].if_ack, g_dut[1].if_rdata, g_dut[1].busy} !== {1'b1, 16'hBEEF, 1'b1}) begin
            n_bad++;
            $display("FAIL if_ack: got ack=%b rdata=%h busy=%b expected ack=1 rdata=beef busy=1",
                     g_dut[1].if_ack, g_dut[1].if_rdata, g_dut[1].busy);
        end
        if_req = 1'b0;
        tick();
        n_cmp++;
        if ({g_dut[1].busy, g_dut[1].if_ack, g_dut[1].grant, g_dut[1].if_rdata} !== {1'b0, 1'b0, 2'b00, 16'hBEEF}) begin
            n_bad++;
            $display("FAIL if_after: got busy=%b ack=%b grant=%b rdata=%h expected busy=0 ack=0 grant=00 rdata=beef",
                     g_dut[1].busy, g_dut[1].if_ack, g_dut[1].grant, g_dut[1].if_rdata);
        end
        settle();
    endtask

    task automatic test_dm_write();
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 16'h0200;
        dm_wdata = 16'h1234;
        tick();
        n_cmp++;
        if ({g_dut[1].mem_en, g_dut[1].mem_we, g_dut[1].grant, g_dut[1].mem_addr, g_dut[1].mem_wdata} !==
            {1'b1, 1'b1, 2'b10, 16'h0200, 16'h1234}) begin
            n_bad++;
            $display("FAIL dm_wr_issue: got en=%b we=%b grant=%b addr=%h wdata=%h expected en=1 we=1 grant=10 addr=0200 wdata=1234",
                     g_dut[1].mem_en, g_dut[1].mem_we, g_dut[1].grant, g_dut[1].mem_addr, g_dut[1].mem_wdata);
        end
        tick();
        n_cmp++;
        if ({g_dut[1].dm_ack, g_dut[1].if_ack, g_dut[1].dm_rdata} !== {1'b1, 1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL dm_wr_ack: got dm_ack=%b if_ack=%b dm_rdata=%h expected dm_ack=1 if_ack=0 dm_rdata=0000",
                     g_dut[1].dm_ack, g_dut[1].if_ack, g_dut[1].dm_rdata);
        end
        dm_req = 1'b0;
        tick();
        n_cmp++;
        if ({g_dut[1].dm_ack, g_dut[1].busy, g_dut[1].dm_rdata} !== {1'b0, 1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL dm_wr_after: got ack=%b busy=%b dm_rdata=%h expected ack=0 busy=0 dm_rdata=0000",
                     g_dut[1].dm_ack, g_dut[1].busy, g_dut[1].dm_rdata);
        end
        settle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        logic [7:0] exp;
        got = '0;
        exp = '0;
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 16'h0300;
        dm_wdata = 16'hA5A5;
        for (int k = 1; k <= 8; k++) begin
            tick();
            got[k-1] = g_dut[1].dm_ack;
            exp[k-1] = ((k % 3) == 2);
        end
        dm_req = 1'b0;
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL b2b_write_acks: got %b expected %b", got, exp);
        end
        settle();
    endtask

`ifndef ARB_RR_EN
    task automatic test_priority();
        if_req = 1'b1;
        if_addr = 16'h0010;
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 16'h0201;
        dm_wdata = 16'h5678;
        tick();
        n_cmp++;
        if ({g_dut[1].grant, g_dut[1].mem_we} !== 3'b101) begin
            n_bad++;
            $display("FAIL prio_c1: got grant=%b we=%b expected grant=10 we=1", g_dut[1].grant, g_dut[1].mem_we);
        end
        tick();
        n_cmp++;
        if ({g_dut[1].grant, g_dut[1].dm_ack, g_dut[1].if_ack} !== 4'b1010) begin
            n_bad++;
            $display("FAIL prio_c2: got grant=%b dm_ack=%b if_ack=%b expected grant=10 dm_ack=1 if_ack=0",
                     g_dut[1].grant, g_dut[1].dm_ack, g_dut[1].if_ack);
        end
        dm_req = 1'b0;
        tick();
        n_cmp++;
        if ({g_dut[1].grant, g_dut[1].busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL prio_c3: got grant=%b busy=%b expected grant=00 busy=0", g_dut[1].grant, g_dut[1].busy);
        end
        tick();
        n_cmp++;
        if ({g_dut[1].grant, g_dut[1].mem_en, g_dut[1].mem_addr} !== {2'b01, 1'b1, 16'h0010}) begin
            n_bad++;
            $display("FAIL prio_c4: got grant=%b en=%b addr=%h expected grant=01 en=1 addr=0010",
                     g_dut[1].grant, g_dut[1].mem_en, g_dut[1].mem_addr);
        end
        repeat (3) tick();
        n_cmp++;
        if ({g_dut[1].if_ack, g_dut[1].if_rdata} !== {1'b1, 16'hBEEF}) begin
            n_bad++;
            $display("FAIL prio_c7: got if_ack=%b rdata=%h expected if_ack=1 rdata=beef", g_dut[1].if_ack, g_dut[1].if_rdata);
        end
        if_req = 1'b0;
        settle();
    endtask
`else
    task automatic test_round_robin();
        logic want_if;
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        if_req = 1'b1;
        if_addr = 16'h0010;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            want_if = ((k % 2) == 0);
            tick();
            n_cmp++;
            if (g_dut[0].grant !== (want_if ? 2'b01 : 2'b10)) begin
                n_bad++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", k, g_dut[0].grant, want_if ? 2'b01 : 2'b10);
            end
            tick();
            tick();
            n_cmp++;
            if ({g_dut[0].if_ack, g_dut[0].dm_ack} !== (want_if ? 2'b10 : 2'b01)) begin
                n_bad++;
                $display("FAIL rr_ack[%0d]: got if/dm=%b expected %b", k, {g_dut[0].if_ack, g_dut[0].dm_ack},
                         want_if ? 2'b10 : 2'b01);
            end
            n_cmp++;
            if ((want_if ? g_dut[0].if_rdata : g_dut[0].dm_rdata) !== (want_if ? 16'hBEEF : 16'h1234)) begin
                n_bad++;
                $display("FAIL rr_data[%0d]: got %h expected %h", k,
                         want_if ? g_dut[0].if_rdata : g_dut[0].dm_rdata, want_if ? 16'hBEEF : 16'h1234);
            end
            if (k == 3) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            tick();
        end
        settle();
    endtask
`endif

    task automatic test_reset_abort();
        logic saw_ack;
        if_req = 1'b1;
        if_addr = 16'h0010;
        tick();
        tick();
        Reset = 1'b0;
        if_req = 1'b0;
        tick();
        n_cmp++;
        if ({g_dut[1].busy, g_dut[1].grant, g_dut[1].if_ack, g_dut[1].state_dbg} !== 6'b0) begin
            n_bad++;
            $display("FAIL abort_reset: got busy=%b grant=%b ack=%b state=%b expected all 0",
                     g_dut[1].busy, g_dut[1].grant, g_dut[1].if_ack, g_dut[1].state_dbg);
        end
        Reset = 1'b1;
        saw_ack = 1'b0;
        repeat (4) begin
            tick();
            saw_ack = saw_ack | g_dut[1].if_ack;
        end
        n_cmp++;
        if (saw_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_ack: got %b expected 0", saw_ack);
        end
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 16'h0200;
        repeat (4) tick();
        n_cmp++;
        if ({g_dut[1].dm_ack, g_dut[1].dm_rdata, g_dut[1].if_rdata} !== {1'b1, 16'h1234, 16'h0000}) begin
            n_bad++;
            $display("FAIL abort_dm_read: got ack=%b dm_rdata=%h if_rdata=%h expected ack=1 dm_rdata=1234 if_rdata=0000",
                     g_dut[1].dm_ack, g_dut[1].dm_rdata, g_dut[1].if_rdata);
        end
        dm_req = 1'b0;
        settle();
    endtask

    task automatic test_long_latency();
        logic early;
        logic late_en;
        early = 1'b0;
        late_en = 1'b0;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 16'h0010;
        repeat (3) tick();
        dm_req = 1'b0;
        early = g_dut[2].dm_ack;
        for (int k = 4; k <= 8; k++) begin
            tick();
            early = early | g_dut[2].dm_ack;
        end
        n_cmp++;
        if (early !== 1'b0) begin
            n_bad++;
            $display("FAIL lat7_early_ack: got %b expected 0", early);
        end
        tick();
        n_cmp++;
        if ({g_dut[2].dm_ack, g_dut[2].dm_rdata} !== {1'b1, 16'hBEEF}) begin
            n_bad++;
            $display("FAIL lat7_ack: got ack=%b rdata=%h expected ack=1 rdata=beef", g_dut[2].dm_ack, g_dut[2].dm_rdata);
        end
        repeat (5) begin
            tick();
            late_en = late_en | g_dut[2].mem_en;
        end
        n_cmp++;
        if (late_en !== 1'b0) begin
            n_bad++;
            $display("FAIL lat7_idle_en: got %b expected 0", late_en);
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_dm_write();
        test_back_to_back();
`ifndef ARB_RR_EN
        test_priority();
`else
        test_round_robin();
`endif
        test_reset_abort();
        test_long_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-port 16-bit memory between two requesters:
  - instruction-fetch port (IF, read-only);
  - data port (DM, read/write).
- Sits between the multi-cycle controller's IMRead/DMRead/DMWrite request paths and a unified memory with fixed read latency.
- Each access is one handshake transaction: request held until a one-cycle ack, with read data registered at ack.

## Interface
Parameters:
- AW, 16, address width
- DW, 16, data width
- MEM_LAT, 1, cycles from memory-enable cycle to valid mem_rdata; legal range 1..7

Ports:
- Clk  in  1  clock; all logic on rising edge
- Reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  AW  fetch address
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  DW  fetched word; updated only with if_ack, held otherwise
- dm_req  in  1  data request, held until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_ack  out  1  one-cycle completion pulse
- dm_rdata  out  DW  read word; updated only on a read dm_ack, held otherwise
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  transaction in progress
- grant  out  2  01 = IF owns memory, 10 = DM owns memory, 00 = none

## Operation
States: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - No request: stay in IDLE.
  - Any req high: pick the winner, latch its addr/we/wdata and grant, go to ISSUE.
  - Requests that drop before being sampled in IDLE are ignored.
- ISSUE
  - mem_en = 1; mem_we = latched we (always 0 for IF).
  - mem_addr/mem_wdata driven from latched registers.
  - Write: go to DONE.
  - Read: load counter with MEM_LAT, go to WAIT.
- WAIT
  - Counter decrements each cycle.
  - On the cycle it reads 1: capture mem_rdata into the granted port's rdata register, go to DONE.
- DONE
  - Granted port's ack = 1 for exactly this cycle; go to IDLE.
- Arbitration when both req are high in IDLE: DM wins (fixed priority; see Configuration).
- Input changes after ISSUE are ignored. A req dropped mid-transaction does not abort it; ack still pulses.
- busy = 1 in ISSUE, WAIT, DONE.
- grant holds the latched winner from ISSUE through DONE; 00 in IDLE.
- mem_addr/mem_wdata hold their last latched values between transactions; only mem_en/mem_we qualify them.
- Reset values, while Reset is low:
  - if_ack, dm_ack, mem_en, mem_we, busy = 0
  - grant = 00
  - if_rdata, dm_rdata, mem_addr, mem_wdata, counter = 0
  - state = IDLE
  - round-robin pointer = DM-last

## Timing
- Request sampled in IDLE at cycle T.
  - Read: ISSUE at T+1, mem_rdata valid at T+1+MEM_LAT, ack and rdata at T+2+MEM_LAT.
  - Write: ISSUE (memory writes) at T+1, ack at T+2.
- A request held continuously is re-sampled in the IDLE cycle after DONE.
  - Back-to-back reads from one port: one ack every MEM_LAT+3 cycles.
  - Back-to-back writes: one ack every 3 cycles.
- Reset low in any state: state is IDLE on the next edge. The in-flight access is abandoned, no ack is issued, and later mem_rdata is ignored.
- No combinational path from any req input to mem_* or ack outputs.

## Configuration
- ARB_RR_EN defined:
  - Round-robin on simultaneous requests; the port not granted last wins.
  - The pointer updates on each entry to ISSUE.
  - After reset the pointer is DM-last, so IF wins the first tie.
  - A single requester always wins, whatever the pointer.
- ARB_RR_EN undefined:
  - Fixed priority, DM always wins a tie.
  - No pointer register is implemented.

## Test plan
- MEM_LAT=2, if_req at cycle 0, if_addr=0x0010, memory returns 0xBEEF:
  - mem_en=1 and mem_addr=0x0010 at cycle 1;
  - if_ack=1 and if_rdata=0xBEEF at cycle 4;
  - busy=0 at cycle 5.
- DM write, dm_addr=0x0200, dm_wdata=0x1234, at cycle 0:
  - mem_en=mem_we=1 at cycle 1;
  - dm_ack at cycle 2;
  - dm_rdata unchanged.
- Macro off, IF read and DM write both requested at cycle 0:
  - grant=10 at cycles 1–2;
  - IF ISSUE at cycle 4, grant=01.
- Macro on, both requests held high, MEM_LAT=1:
  - grants alternate IF, DM, IF, DM starting with IF;
  - no port is acked twice in a row.
- Reset low during WAIT of an IF read:
  - next cycle busy=0, grant=00, no if_ack;
  - a following dm read completes normally with correct data.
- MEM_LAT=7 read while dm_req drops at cycle 3 (after ISSUE):
  - dm_ack still pulses at cycle 9;
  - mem_en stays 0 afterwards.
